alu_exec: RTL
=============

Name: alu_exec

Overview:
- Execute-stage unit on the consumer side of the ALU decoder.
- Takes the 8-bit alucontrol code (EXE_*_OP encodings from defines.vh) plus operands, and produces a registered result, a zero flag and the HI/LO registers.
- Single-cycle ops complete in 1 cycle. DIV/DIVU run an iterative 32-step restoring divider and stall the pipeline through ready_o.

Parameters:
- DIV_STEPS, 32, divider iteration count; must equal the data width.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous active-low reset
- valid_i  in  1  operation present
- ready_o  out  1  unit can accept; low while dividing
- flush_i  in  1  abort in-flight division / drop incoming op
- alucontrol_i  in  8  EXE_*_OP code
- a_i  in  32  rs operand
- b_i  in  32  rt operand / immediate
- sa_i  in  5  shamt for SLL/SRL/SRA
- valid_o  out  1  one-cycle result pulse
- result_o  out  32  registered result
- zero_o  out  1  result_o == 0
- ov_o  out  1  signed overflow (see Optional Feature)
- hi_o  out  32  HI register
- lo_o  out  32  LO register

Behaviour:
- Reset: resetn low at a clk edge sets:
  - state IDLE;
  - result_o, hi_o, lo_o = 0;
  - valid_o, zero_o, ov_o = 0;
  - ready_o reads 1 afterwards.
  - Reset mid-division aborts it.
- States: IDLE, DIV.
  - ready_o = (state == IDLE), combinational from state.
- Accept: valid_i & ready_o & !flush_i sampled at edge N. No downstream backpressure.
- Simple ops (accepted at N): result_o/zero_o/ov_o registered at edge N; valid_o high for the following cycle only.
  - ADD, ADDU: a+b mod 2^32.
  - SUB, SUBU: a-b mod 2^32.
  - AND, OR, XOR, NOR: bitwise.
  - SLT: signed compare, result 0 or 1. SLTU: unsigned compare, result 0 or 1.
  - SLL, SRL, SRA: shift b_i by sa_i.
  - SLLV, SRLV, SRAV: shift b_i by a_i[4:0].
  - SRA and SRAV are arithmetic shifts.
- NOP (8'h00) or any unlisted code: result_o = 0, zero_o = 1, ov_o = 0, valid_o still pulses.
- MULT/MULTU: 64-bit signed/unsigned product. hi_o = [63:32], lo_o = [31:0], both written at edge N. valid_o pulses; result_o unchanged.
- DIV/DIVU, divisor != 0:
  - Edge N: latch |a|, |b| (signed) or a, b (unsigned) and the operand signs; enter DIV; ready_o low.
  - Edges N+1..N+32: one restoring step each.
  - Edge N+33: apply sign fix-up, write lo_o = quotient and hi_o = remainder, return to IDLE.
  - Cycle after N+33: valid_o high and ready_o high; a new op may be accepted in that same cycle.
  - Signed results: quotient negative iff operand signs differ; remainder takes the dividend's sign.
- DIV/DIVU, divisor == 0: no DIV state. lo_o = 32'hFFFFFFFF, hi_o = a_i, written at edge N; valid_o pulses the next cycle.
- flush_i:
  - In DIV: returns to IDLE next edge; no valid_o; hi_o/lo_o unchanged.
  - With valid_i in IDLE: the op is dropped (flush wins).
  - Does not retract a valid_o already registered.
- valid_i while ready_o = 0 is ignored; the upstream stage holds its op.

Optional Feature:
- Macro: ALU_OVF_DETECT_EN.
- Defined: ov_o = signed overflow of ADD/SUB, registered with result_o. result_o still holds the wrapped value; writeback suppression is the pipeline's job. ADDU/SUBU never set ov_o.
- Undefined: ov_o tied to 0 and no overflow logic is synthesized.

Test Plan:
1. ADD a=7, b=5 accepted at N -> valid_o in cycle N+1, result_o=12, zero_o=0. Then SUB a=5, b=5 -> result_o=0, zero_o=1.
2. SRA sa_i=4, b=32'h80000000 -> 32'hF8000000. SRLV a_i=4, same b -> 32'h08000000. Unlisted code 8'h3F -> result_o=0, valid_o pulses.
3. MULT a=32'hFFFFFFFE, b=3 -> hi_o=32'hFFFFFFFF, lo_o=32'hFFFFFFFA. MULTU same operands -> hi_o=2, lo_o=32'hFFFFFFFA.
4. DIV a=32'hFFFFFFF9 (-7), b=2 -> ready_o low for 33 cycles, then lo_o=32'hFFFFFFFD, hi_o=32'hFFFFFFFF, with valid_o after edge N+33. DIVU a=100, b=7 -> lo_o=14, hi_o=2. Back-to-back ADD accepted in the valid_o cycle.
5. DIV in progress with flush_i at N+10 -> no valid_o, hi_o/lo_o unchanged, ready_o=1 after the next edge. resetn low mid-DIV -> all outputs 0, state IDLE. DIV a=9, b=0 -> lo_o=32'hFFFFFFFF, hi_o=9, valid_o at N+1.
6. ADD a=32'h7FFFFFFF, b=1 -> result_o=32'h80000000. ov_o=1 with ALU_OVF_DETECT_EN, ov_o=0 without it. ADDU with the same operands -> ov_o=0 in both builds.

Source files
------------

// File: rtl/alu_exec.sv
`default_nettype none
// ============================================================================
// Module   : alu_exec
// Purpose  : Execute-stage ALU with registered result/zero, HI/LO multiply
//            and a 32-step iterative restoring divider that stalls via ready_o.
//            Optional macro ALU_OVF_DETECT_EN enables signed-overflow on ov_o.
// Revision : 1.0  initial release
// ============================================================================
module alu_exec #(
    parameter int DIV_STEPS = 32
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid_i,
    output logic        ready_o,
    input  logic        flush_i,
    input  logic [7:0]  alucontrol_i,
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic [4:0]  sa_i,
    output logic        valid_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        ov_o,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    localparam logic [7:0] c_NOP_OP   = 8'h00;
    localparam logic [7:0] c_SRL_OP   = 8'h02;
    localparam logic [7:0] c_SRA_OP   = 8'h03;
    localparam logic [7:0] c_SLLV_OP  = 8'h04;
    localparam logic [7:0] c_SRLV_OP  = 8'h06;
    localparam logic [7:0] c_SRAV_OP  = 8'h07;
    localparam logic [7:0] c_MULT_OP  = 8'h18;
    localparam logic [7:0] c_MULTU_OP = 8'h19;
    localparam logic [7:0] c_DIV_OP   = 8'h1A;
    localparam logic [7:0] c_DIVU_OP  = 8'h1B;
    localparam logic [7:0] c_ADD_OP   = 8'h20;
    localparam logic [7:0] c_ADDU_OP  = 8'h21;
    localparam logic [7:0] c_SUB_OP   = 8'h22;
    localparam logic [7:0] c_SUBU_OP  = 8'h23;
    localparam logic [7:0] c_AND_OP   = 8'h24;
    localparam logic [7:0] c_OR_OP    = 8'h25;
    localparam logic [7:0] c_XOR_OP   = 8'h26;
    localparam logic [7:0] c_NOR_OP   = 8'h27;
    localparam logic [7:0] c_SLT_OP   = 8'h2A;
    localparam logic [7:0] c_SLTU_OP  = 8'h2B;
    localparam logic [7:0] c_SLL_OP   = 8'h7C;

    localparam int            c_CW   = $clog2(DIV_STEPS + 1);
    localparam logic [c_CW-1:0] c_LAST = c_CW'(DIV_STEPS);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_DIV  = 1'b1
    } state_t;

    state_t          r_state;
    logic            r_valid;
    logic            r_zero;
    logic [31:0]     r_result;
    logic [31:0]     r_hi;
    logic [31:0]     r_lo;
    logic [31:0]     r_rem;
    logic [31:0]     r_quo;
    logic [31:0]     r_dvsr;
    logic [c_CW-1:0] r_cnt;
    logic            r_neg_q;
    logic            r_neg_r;

    logic        w_accept;
    logic        w_muldiv;
    logic [31:0] w_res;
    logic        w_mul_s;
    logic [63:0] w_mul_a;
    logic [63:0] w_mul_b;
    logic [63:0] w_prod;
    logic        w_div_s;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [32:0] w_rem_sh;
    logic [32:0] w_trial;
    logic        w_ge;
    logic [31:0] w_q_fix;
    logic [31:0] w_r_fix;

    assign ready_o  = (r_state == S_IDLE);
    assign w_accept = valid_i & ready_o & ~flush_i;
    assign valid_o  = r_valid;
    assign result_o = r_result;
    assign zero_o   = r_zero;
    assign hi_o     = r_hi;
    assign lo_o     = r_lo;

    assign w_muldiv = (alucontrol_i == c_MULT_OP) || (alucontrol_i == c_MULTU_OP) ||
                      (alucontrol_i == c_DIV_OP)  || (alucontrol_i == c_DIVU_OP);

    always_comb begin
        w_res = 32'h0;
        case (alucontrol_i)
            c_ADD_OP, c_ADDU_OP: w_res = a_i + b_i;
            c_SUB_OP, c_SUBU_OP: w_res = a_i - b_i;
            c_AND_OP:            w_res = a_i & b_i;
            c_OR_OP:             w_res = a_i | b_i;
            c_XOR_OP:            w_res = a_i ^ b_i;
            c_NOR_OP:            w_res = ~(a_i | b_i);
            c_SLT_OP:            w_res = {31'h0, $signed(a_i) < $signed(b_i)};
            c_SLTU_OP:           w_res = {31'h0, a_i < b_i};
            c_SLL_OP:            w_res = b_i << sa_i;
            c_SRL_OP:            w_res = b_i >> sa_i;
            c_SRA_OP:            w_res = $signed(b_i) >>> sa_i;
            c_SLLV_OP:           w_res = b_i << a_i[4:0];
            c_SRLV_OP:           w_res = b_i >> a_i[4:0];
            c_SRAV_OP:           w_res = $signed(b_i) >>> a_i[4:0];
            c_NOP_OP:            w_res = 32'h0;
            default:             w_res = 32'h0;
        endcase
    end

    // One shared 64x64 multiplier; sign-extending the operands yields the signed product.
    assign w_mul_s = (alucontrol_i == c_MULT_OP);
    assign w_mul_a = w_mul_s ? {{32{a_i[31]}}, a_i} : {32'h0, a_i};
    assign w_mul_b = w_mul_s ? {{32{b_i[31]}}, b_i} : {32'h0, b_i};
    assign w_prod  = w_mul_a * w_mul_b;

    assign w_div_s = (alucontrol_i == c_DIV_OP);
    assign w_a_neg = w_div_s & a_i[31];
    assign w_b_neg = w_div_s & b_i[31];

    // Dividend is shifted out of r_quo's MSB while quotient bits shift in at the LSB.
    assign w_rem_sh = {r_rem, r_quo[31]};
    assign w_trial  = w_rem_sh - {1'b0, r_dvsr};
    assign w_ge     = ~w_trial[32];
    assign w_q_fix  = r_neg_q ? (32'h0 - r_quo) : r_quo;
    assign w_r_fix  = r_neg_r ? (32'h0 - r_rem) : r_rem;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state  <= S_IDLE;
            r_valid  <= 1'b0;
            r_zero   <= 1'b0;
            r_result <= 32'h0;
            r_hi     <= 32'h0;
            r_lo     <= 32'h0;
            r_rem    <= 32'h0;
            r_quo    <= 32'h0;
            r_dvsr   <= 32'h0;
            r_cnt    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        case (alucontrol_i)
                            c_MULT_OP, c_MULTU_OP: begin
                                r_hi    <= w_prod[63:32];
                                r_lo    <= w_prod[31:0];
                                r_valid <= 1'b1;
                            end
                            c_DIV_OP, c_DIVU_OP: begin
                                if (b_i == 32'h0) begin
                                    r_lo    <= 32'hFFFF_FFFF;
                                    r_hi    <= a_i;
                                    r_valid <= 1'b1;
                                end else begin
                                    r_quo   <= w_a_neg ? (32'h0 - a_i) : a_i;
                                    r_dvsr  <= w_b_neg ? (32'h0 - b_i) : b_i;
                                    r_rem   <= 32'h0;
                                    r_neg_q <= w_a_neg ^ w_b_neg;
                                    r_neg_r <= w_a_neg;
                                    r_cnt   <= '0;
                                    r_state <= S_DIV;
                                end
                            end
                            default: begin
                                r_result <= w_res;
                                r_zero   <= (w_res == 32'h0);
                                r_valid  <= 1'b1;
                            end
                        endcase
                    end
                end
                S_DIV: begin
                    if (flush_i) begin
                        r_state <= S_IDLE;
                    end else if (r_cnt == c_LAST) begin
                        r_lo    <= w_q_fix;
                        r_hi    <= w_r_fix;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_rem <= w_ge ? w_trial[31:0] : w_rem_sh[31:0];
                        r_quo <= {r_quo[30:0], w_ge};
                        r_cnt <= r_cnt + c_CW'(1);
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

`ifdef ALU_OVF_DETECT_EN
    logic w_ov;
    logic r_ov;

    always_comb begin
        w_ov = 1'b0;
        case (alucontrol_i)
            c_ADD_OP: w_ov = (a_i[31] == b_i[31]) && (w_res[31] != a_i[31]);
            c_SUB_OP: w_ov = (a_i[31] != b_i[31]) && (w_res[31] != a_i[31]);
            default:  w_ov = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_ov <= 1'b0;
        end else if (w_accept && !w_muldiv) begin
            r_ov <= w_ov;
        end
    end

    assign ov_o = r_ov;
`else
    assign ov_o = 1'b0;
`endif

endmodule
`default_nettype wire
